// File: rtl/mtm_alu_serializer_if.sv
// Result bus between the ALU core and the output serializer.
// The core drives the response request; the serializer drives the pin and busy.
interface mtm_alu_serializer_if;
    logic        start;
    logic [31:0] C;
    logic [3:0]  FLAGS;
    logic        ERR;
    logic [5:0]  ERR_FLAGS;
    logic        sout;
    logic        busy;

    modport master (
        output start, C, FLAGS, ERR, ERR_FLAGS,
        input  sout, busy
    );

    modport slave (
        input  start, C, FLAGS, ERR, ERR_FLAGS,
        output sout, busy
    );
endinterface

// File: rtl/mtm_alu_serializer.sv
// MTM ALU output serializer: sends a result as 11-bit frames on one line.
// Normal responses are 4 DATA frames plus a CRC'd CMD frame; errors are one CMD frame.
module mtm_alu_serializer (
    input  logic                  clk,
    input  logic                  rst,
    mtm_alu_serializer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TYPE,
        S_PAYLOAD,
        S_STOP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_bit;
    logic [2:0]  r_frame;
    logic [31:0] r_c;
    logic [7:0]  r_ctl;
    logic        r_err;

    logic        w_accept;
    logic        w_last;
    logic [7:0]  w_byte;
    logic [7:0]  w_ctl;

    // Bit-serial x^3+x+1 over {C, 1'b0, FLAGS}, MSB first, seed 000.
    function automatic logic [2:0] crc3(
        input logic [31:0] c,
        input logic [3:0]  f
    );
        logic [36:0] m;
        logic [2:0]  crc;
        logic        fb;
        m   = {c, 1'b0, f};
        crc = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ m[i];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
        return crc;
    endfunction

    assign w_accept = bus.start && (r_state == S_IDLE);

    always_comb begin
        w_ctl = 8'h00;
        if (bus.ERR)
            w_ctl = {1'b1, bus.ERR_FLAGS, ~(^bus.ERR_FLAGS)};
        else
            w_ctl = {1'b0, bus.FLAGS, crc3(bus.C, bus.FLAGS)};
    end

    assign w_last = r_err ? (r_frame == 3'd0) : (r_frame == 3'd4);

    always_comb begin
        w_byte = r_ctl;
        if (!w_last) begin
            unique case (r_frame)
                3'd0:    w_byte = r_c[31:24];
                3'd1:    w_byte = r_c[23:16];
                3'd2:    w_byte = r_c[15:8];
                3'd3:    w_byte = r_c[7:0];
                default: w_byte = r_ctl;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (bus.start) w_next = S_START;
            S_START:   w_next = S_TYPE;
            S_TYPE:    w_next = S_PAYLOAD;
            S_PAYLOAD: if (r_bit == 3'd0) w_next = S_STOP;
            S_STOP:    w_next = w_last ? S_IDLE : S_START;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bit   <= 3'd0;
            r_frame <= 3'd0;
            r_c     <= 32'h0;
            r_ctl   <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_c     <= bus.C;
                r_ctl   <= w_ctl;
                r_err   <= bus.ERR;
                r_frame <= 3'd0;
            end
            if (r_state == S_TYPE)
                r_bit <= 3'd7;
            else if (r_state == S_PAYLOAD)
                r_bit <= r_bit - 3'd1;
            if (r_state == S_STOP && !w_last)
                r_frame <= r_frame + 3'd1;
        end
    end

    // Line level is a pure function of state so reset forces idle at once.
    always_comb begin
        bus.sout = 1'b1;
        bus.busy = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE:    bus.sout = 1'b1;
            S_START:   bus.sout = 1'b0;
            S_TYPE:    bus.sout = w_last;
            S_PAYLOAD: bus.sout = w_byte[r_bit];
            S_STOP:    bus.sout = 1'b1;
            default:   bus.sout = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for mtm_alu_serializer.
// Frames are sampled on the falling edge and compared to hand-computed bits.
module tb_mtm_alu_serializer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   busy_cnt;

    mtm_alu_serializer_if bus ();

    mtm_alu_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rx_frame(output logic [10:0] f);
        f = 11'h0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            f = {f[9:0], bus.sout};
            if (bus.busy) busy_cnt++;
        end
    endtask

    task automatic set_in(input logic [31:0] c, input logic [3:0] fl,
                          input logic err, input logic [5:0] ef);
        bus.C         = c;
        bus.FLAGS     = fl;
        bus.ERR       = err;
        bus.ERR_FLAGS = ef;
    endtask

    task automatic accept();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic rx_resp(input string tag, input int nfr,
                           input logic [39:0] exp);
        logic [10:0] f;
        logic [7:0]  b;
        busy_cnt = 0;
        for (int k = 0; k < nfr; k++) begin
            rx_frame(f);
            b = exp[39 - 8*k -: 8];
            check($sformatf("%s_f%0d", tag, k), {21'h0, f},
                  {21'h0, 1'b0, (k == nfr - 1), b, 1'b1});
        end
        check({tag, "_busy"}, busy_cnt, nfr * 11);
        @(negedge clk);
        check({tag, "_idle"}, {bus.busy, bus.sout}, 2'b01);
    endtask

    initial begin
        int bad;
        logic [10:0] f;
        n_checks  = 0;
        n_errors  = 0;
        busy_cnt  = 0;
        bus.start = 1'b0;
        set_in(32'h0, 4'h0, 1'b0, 6'h0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset", {bus.busy, bus.sout}, 2'b01);

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.sout !== 1'b1) bad++;
        end
        check("idle100", bad, 0);

        set_in(32'h0000_0000, 4'b0001, 1'b0, 6'h0);
        accept();
        rx_resp("n0", 5, {8'h00, 8'h00, 8'h00, 8'h00, 8'h0B});

        set_in(32'h0000_0001, 4'b0000, 1'b0, 6'h0);
        accept();
        rx_resp("n1", 5, {8'h00, 8'h00, 8'h00, 8'h01, 8'h02});

        set_in(32'h0, 4'h0, 1'b1, 6'b100100);
        accept();
        rx_resp("e0", 1, {8'hC9, 32'h0});

        set_in(32'h0, 4'h0, 1'b1, 6'b010010);
        accept();
        rx_resp("e1", 1, {8'hA5, 32'h0});

        set_in(32'h0000_0001, 4'b0000, 1'b0, 6'h0);
        accept();
        fork
            rx_resp("ign", 5, {8'h00, 8'h00, 8'h00, 8'h01, 8'h02});
            begin
                repeat (15) @(posedge clk);
                #1;
                set_in(32'hFFFF_FFFF, 4'hF, 1'b1, 6'h3F);
                bus.start = 1'b1;
                @(posedge clk);
                #1 bus.start = 1'b0;
            end
        join

        set_in(32'h0, 4'h0, 1'b1, 6'b100100);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        busy_cnt = 0;
        rx_frame(f);
        check("b2b_f0", {21'h0, f}, {21'h0, 11'b0_1_11001001_1});
        @(negedge clk);
        check("b2b_gap", {bus.busy, bus.sout}, 2'b01);
        @(posedge clk);
        #1 bus.start = 1'b0;
        rx_frame(f);
        check("b2b_f1", {21'h0, f}, {21'h0, 11'b0_1_11001001_1});
        check("b2b_busy", busy_cnt, 22);
        @(negedge clk);
        check("b2b_idle", {bus.busy, bus.sout}, 2'b01);

        set_in(32'h0000_0000, 4'b0001, 1'b0, 6'h0);
        accept();
        repeat (27) @(negedge clk);
        check("pre_abort", bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort", {bus.busy, bus.sout}, 2'b01);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_abort", {bus.busy, bus.sout}, 2'b01);

        set_in(32'h0, 4'h0, 1'b1, 6'b010010);
        accept();
        rx_resp("rec", 1, {8'hA5, 32'h0});

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
